// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the single burst-memory port between the I-cache and D-cache.
// Round-robin grant, 4-beat 64-bit bursts, one-cycle 256-bit line responses.
module bmem_arbiter #(
    parameter bit CHECK_RADDR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_dfp_addr,
    input  logic         i_dfp_read,
    output logic [255:0] i_dfp_rdata,
    output logic         i_dfp_resp,
    input  logic [31:0]  d_dfp_addr,
    input  logic         d_dfp_read,
    input  logic         d_dfp_write,
    input  logic [255:0] d_dfp_wdata,
    output logic [255:0] d_dfp_rdata,
    output logic         d_dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]   r_state;
    logic [1:0]   r_cnt;
    logic         r_lastGrant;
    logic [31:0]  r_addr;
    logic [255:0] r_wdata;
    logic [255:0] r_lineBuf;

    logic         w_reqI;
    logic         w_reqD;
    logic         w_grantD;
    logic         w_raddrOk;
    logic         w_beatOk;
    logic         w_isRead;
    logic         w_isWrite;
    logic         w_isResp;
    logic [31:0]  w_grantAddr;
    logic         w_unused;

    // Line offset bits are never used; the whole line is always transferred.
    assign w_unused = ^{i_dfp_addr[4:0], d_dfp_addr[4:0]};

    // r_lastGrant holds the most recently granted port (1 = D), so on a tie the other one wins.
    assign w_reqI      = i_dfp_read;
    assign w_reqD      = d_dfp_read | d_dfp_write;
    assign w_grantD    = w_reqD & (~w_reqI | ~r_lastGrant);
    assign w_grantAddr = w_grantD ? {d_dfp_addr[31:5], 5'b0} : {i_dfp_addr[31:5], 5'b0};

    assign w_raddrOk = !CHECK_RADDR || (bmem_raddr == r_addr);
    assign w_beatOk  = bmem_rvalid && w_raddrOk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_lastGrant <= 1'b1;
            r_addr      <= 32'd0;
            r_wdata     <= 256'd0;
            r_lineBuf   <= 256'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reqI || w_reqD) begin
                        r_lastGrant <= w_grantD;
                        r_addr      <= w_grantAddr;
                        r_cnt       <= 2'd0;
                        if (w_grantD && d_dfp_write) begin
                            r_wdata <= d_dfp_wdata;
                            r_state <= WR_BURST;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bmem_ready) begin
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (w_beatOk) begin
                        r_lineBuf[{r_cnt, 6'b0} +: 64] <= bmem_rdata;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= RESP;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Every output below is a pure decode of registered state.
    assign w_isRead  = (r_state == RD_ISSUE);
    assign w_isWrite = (r_state == WR_BURST);
    assign w_isResp  = (r_state == RESP);

    assign bmem_read   = w_isRead;
    assign bmem_write  = w_isWrite;
    assign bmem_addr   = (w_isRead || w_isWrite) ? r_addr : 32'd0;
    assign bmem_wdata  = w_isWrite ? r_wdata[{r_cnt, 6'b0} +: 64] : 64'd0;

    assign i_dfp_resp  = w_isResp & ~r_lastGrant;
    assign d_dfp_resp  = w_isResp & r_lastGrant;
    assign i_dfp_rdata = r_lineBuf;
    assign d_dfp_rdata = r_lineBuf;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Testbench for bmem_arbiter: a vector table of arbitration cases, hand-written
// multi-cycle corner sequences, and randomized traffic against a line-memory model.
`timescale 1ns/1ps
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  iAddr = '0;
    logic         iRead = 1'b0;
    logic [255:0] iRdata;
    logic         iResp;
    logic [31:0]  dAddr = '0;
    logic         dRead = 1'b0;
    logic         dWrite = 1'b0;
    logic [255:0] dWdata = '0;
    logic [255:0] dRdata;
    logic         dResp;
    logic [31:0]  bAddr;
    logic         bRead;
    logic         bWrite;
    logic [63:0]  bWdata;
    logic         bReady = 1'b0;
    logic [31:0]  bRaddr = '0;
    logic [63:0]  bRdata = '0;
    logic         bRvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    bmem_arbiter #(.CHECK_RADDR(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .i_dfp_addr(iAddr),
        .i_dfp_read(iRead),
        .i_dfp_rdata(iRdata),
        .i_dfp_resp(iResp),
        .d_dfp_addr(dAddr),
        .d_dfp_read(dRead),
        .d_dfp_write(dWrite),
        .d_dfp_wdata(dWdata),
        .d_dfp_rdata(dRdata),
        .d_dfp_resp(dResp),
        .bmem_addr(bAddr),
        .bmem_read(bRead),
        .bmem_write(bWrite),
        .bmem_wdata(bWdata),
        .bmem_ready(bReady),
        .bmem_raddr(bRaddr),
        .bmem_rdata(bRdata),
        .bmem_rvalid(bRvalid)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        iRd;
        logic        dRd;
        logic        dWr;
        logic [31:0] iA;
        logic [31:0] dA;
        logic        expD;
        logic        expWr;
        logic [31:0] expAddr;
    } vec_t;

    vec_t rows[11];

    logic [255:0] memModel [logic [31:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [255:0] wd);
        iRead  = ir;
        iAddr  = ia;
        dRead  = dr;
        dWrite = dw;
        dAddr  = da;
        dWdata = wd;
    endtask

    task automatic setMem(input logic rdy, input logic vld, input logic [31:0] ra, input logic [63:0] rd);
        bReady  = rdy;
        bRvalid = vld;
        bRaddr  = ra;
        bRdata  = rd;
    endtask

    function automatic logic [255:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] memLine(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return {8{a ^ 32'hA5A5_5A5A}};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        setMem(1'b0, 1'b0, 32'd0, 64'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " bmem_read"},  256'(bRead),  256'd0);
        checkOutput({tag, " bmem_write"}, 256'(bWrite), 256'd0);
        checkOutput({tag, " bmem_addr"},  256'(bAddr),  256'd0);
        checkOutput({tag, " bmem_wdata"}, 256'(bWdata), 256'd0);
        checkOutput({tag, " i_resp"},     256'(iResp),  256'd0);
        checkOutput({tag, " d_resp"},     256'(dResp),  256'd0);
        checkOutput({tag, " i_rdata"},    iRdata,       256'd0);
        checkOutput({tag, " d_rdata"},    dRdata,       256'd0);
    endtask

    // Called in the first RD_WAIT cycle; returns in the cycle after the 4th beat.
    task automatic serveBeats(input logic [31:0] ra, input logic [255:0] line);
        for (int k = 0; k < 4; k++) begin
            setMem(1'b1, 1'b1, ra, line[k*64 +: 64]);
            tick();
        end
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
    endtask

    task automatic runTable();
        logic [255:0] line;
        for (int r = 0; r < 11; r++) begin
            line = randLine();
            applyStimulus(rows[r].iRd, rows[r].iA, rows[r].dRd, rows[r].dWr, rows[r].dA, line);
            setMem(1'b1, 1'b0, 32'd0, 64'd0);
            tick();
            checkOutput($sformatf("row%0d bmem_read", r),  256'(bRead),  256'(!rows[r].expWr));
            checkOutput($sformatf("row%0d bmem_write", r), 256'(bWrite), 256'(rows[r].expWr));
            checkOutput($sformatf("row%0d bmem_addr", r),  256'(bAddr),  256'(rows[r].expAddr));
            if (rows[r].expWr) begin
                for (int k = 0; k < 4; k++) begin
                    checkOutput($sformatf("row%0d wdata%0d", r, k), 256'(bWdata), 256'(line[k*64 +: 64]));
                    tick();
                end
            end else begin
                tick();
                serveBeats(rows[r].expAddr, line);
            end
            checkOutput($sformatf("row%0d i_resp", r), 256'(iResp), 256'(!rows[r].expD));
            checkOutput($sformatf("row%0d d_resp", r), 256'(dResp), 256'(rows[r].expD));
            if (!rows[r].expWr) begin
                checkOutput($sformatf("row%0d rdata", r), rows[r].expD ? dRdata : iRdata, line);
            end
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
            tick();
            checkOutput($sformatf("row%0d resp pulse", r), 256'({iResp, dResp}), 256'd0);
        end
    endtask

    task automatic runRandom(input int numTxn);
        logic         lastWasD;
        logic         ir, dr, dw, expD, expWr, rdy, vld, done, addrSeen, readAccepted;
        logic [31:0]  ia, da, expAddr, ra;
        logic [63:0]  rd;
        logic [255:0] wd, wrLine, src;
        int           beatsSent, wrBeats, choice;
        lastWasD = 1'b1;
        for (int t = 0; t < numTxn; t++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            ia = 32'h0004_0000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
            da = 32'h0004_0000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
            wd = randLine();
            expD     = (dr || dw) && (!ir || !lastWasD);
            expWr    = expD && dw;
            expAddr  = (expD ? da : ia) & 32'hFFFF_FFE0;
            lastWasD = expD;
            src      = memLine(expAddr);
            wrLine = '0; wrBeats = 0; beatsSent = 0;
            done = 1'b0; addrSeen = 1'b0; readAccepted = 1'b0;
            tick();
            applyStimulus(ir, ia, dr, dw, da, wd);
            setMem(1'b0, 1'b0, 32'd0, 64'd0);
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                tick();
                if (iResp || dResp) begin
                    checkOutput($sformatf("rand%0d resp port", t), 256'({iResp, dResp}), 256'({!expD, expD}));
                    if (expWr) begin
                        checkOutput($sformatf("rand%0d write beats", t), 256'(wrBeats), 256'd4);
                        checkOutput($sformatf("rand%0d write line", t), wrLine, wd);
                        memModel[expAddr] = wd;
                    end else begin
                        checkOutput($sformatf("rand%0d read line", t), expD ? dRdata : iRdata, src);
                    end
                    done = 1'b1;
                    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
                    setMem(1'b0, 1'b0, 32'd0, 64'd0);
                end else begin
                    if ((bRead || bWrite) && !addrSeen) begin
                        checkOutput($sformatf("rand%0d addr", t), 256'(bAddr), 256'(expAddr));
                        checkOutput($sformatf("rand%0d op", t), 256'(bWrite), 256'(expWr));
                        addrSeen = 1'b1;
                    end
                    rdy = ($urandom_range(0, 3) != 0);
                    vld = 1'b0; ra = 32'd0; rd = 64'd0;
                    if (bWrite && rdy && wrBeats < 4) begin
                        wrLine[wrBeats*64 +: 64] = bWdata;
                        wrBeats++;
                    end
                    if (readAccepted && beatsSent < 4) begin
                        choice = $urandom_range(0, 3);
                        if (choice == 1) begin
                            vld = 1'b1; ra = expAddr ^ 32'h20; rd = {$urandom, $urandom};
                        end else if (choice >= 2) begin
                            vld = 1'b1; ra = expAddr; rd = src[beatsSent*64 +: 64];
                            beatsSent++;
                        end
                    end else if (!readAccepted && $urandom_range(0, 4) == 0) begin
                        vld = 1'b1; ra = expAddr; rd = {$urandom, $urandom};
                    end
                    if (bRead && rdy) readAccepted = 1'b1;
                    setMem(rdy, vld, ra, rd);
                end
            end
            if (!done) begin
                checkOutput($sformatf("rand%0d completion", t), 256'd0, 256'd1);
                applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
                setMem(1'b0, 1'b0, 32'd0, 64'd0);
            end
        end
    endtask

    initial begin
        logic [255:0] line;
        logic [63:0]  expW [5];
        logic         rdyPat [5];

        rows[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,          1'b0, 1'b0, 32'h0000_1220};
        rows[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_2345, 1'b1, 1'b0, 32'h0000_2340};
        rows[2]  = '{1'b1, 1'b1, 1'b0, 32'h0003_001F, 32'h0004_001F, 1'b0, 1'b0, 32'h0003_0000};
        rows[3]  = '{1'b1, 1'b1, 1'b0, 32'h5000_0008, 32'h6000_0010, 1'b1, 1'b0, 32'h6000_0000};
        rows[4]  = '{1'b0, 1'b1, 1'b1, 32'h0,          32'h0000_7FFF, 1'b1, 1'b1, 32'h0000_7FE0};
        rows[5]  = '{1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'h9000_0002, 1'b0, 1'b0, 32'h8000_0000};
        rows[6]  = '{1'b1, 1'b0, 1'b1, 32'hA000_0040, 32'hB000_005F, 1'b1, 1'b1, 32'hB000_0040};
        rows[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,          32'hC000_0021, 1'b1, 1'b1, 32'hC000_0020};
        rows[8]  = '{1'b1, 1'b1, 1'b0, 32'hD000_00FF, 32'hE000_0000, 1'b0, 1'b0, 32'hD000_00E0};
        rows[9]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0, 32'hFFFF_FFE0};
        rows[10] = '{1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 32'h2222_2220};

        doReset();
        checkAllZero("reset");
        runTable();

        // Minimum-latency I read with literal beat values.
        line = {64'hD, 64'hC, 64'hB, 64'hA};
        applyStimulus(1'b1, 32'h1ECE_B004, 1'b0, 1'b0, 32'd0, 256'd0);
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        tick();
        checkOutput("iread bmem_read", 256'(bRead), 256'd1);
        checkOutput("iread bmem_addr", 256'(bAddr), 256'h1ECE_B000);
        tick();
        checkOutput("iread read one cycle", 256'(bRead), 256'd0);
        serveBeats(32'h1ECE_B000, line);
        checkOutput("iread i_resp cycle6", 256'(iResp), 256'd1);
        checkOutput("iread i_rdata", iRdata, line);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        // D write with one not-ready cycle holding beat 1.
        expW   = '{64'd1, 64'd2, 64'd2, 64'd3, 64'd4};
        rdyPat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_1000, {64'd4, 64'd3, 64'd2, 64'd1});
        tick();
        checkOutput("dwrite bmem_addr", 256'(bAddr), 256'h1000);
        for (int k = 0; k < 5; k++) begin
            setMem(rdyPat[k], 1'b0, 32'd0, 64'd0);
            checkOutput($sformatf("dwrite bmem_write c%0d", k + 1), 256'(bWrite), 256'd1);
            checkOutput($sformatf("dwrite bmem_wdata c%0d", k + 1), 256'(bWdata), 256'(expW[k]));
            tick();
        end
        checkOutput("dwrite write ends", 256'(bWrite), 256'd0);
        checkOutput("dwrite d_resp cycle6", 256'(dResp), 256'd1);
        checkOutput("dwrite no i_resp", 256'(iResp), 256'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        // Tie after reset goes to I; I re-requesting beside a held D then loses to D.
        doReset();
        line = randLine();
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 256'd0);
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        tick();
        checkOutput("tie1 grant I addr", 256'(bAddr), 256'h100);
        tick();
        serveBeats(32'h0000_0100, line);
        checkOutput("tie1 i_resp", 256'(iResp), 256'd1);
        checkOutput("tie1 d_resp", 256'(dResp), 256'd0);
        iRead = 1'b0;
        tick();
        checkOutput("tie1 idle no read", 256'(bRead), 256'd0);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0200, 256'd0);
        tick();
        checkOutput("tie2 bmem_read", 256'(bRead), 256'd1);
        checkOutput("tie2 grant D addr", 256'(bAddr), 256'h200);
        line = randLine();
        tick();
        serveBeats(32'h0000_0200, line);
        checkOutput("tie2 d_resp", 256'(dResp), 256'd1);
        checkOutput("tie2 d_rdata", dRdata, line);
        dRead = 1'b0;
        tick();
        tick();
        checkOutput("tie2 held I addr", 256'(bAddr), 256'h300);
        line = randLine();
        tick();
        serveBeats(32'h0000_0300, line);
        checkOutput("tie2 i_resp", 256'(iResp), 256'd1);
        checkOutput("tie2 i_rdata", iRdata, line);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        // Stray beat from another line in the middle of a read.
        line = randLine();
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'd0, 256'd0);
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        tick();
        tick();
        setMem(1'b1, 1'b1, 32'h0000_2000, line[63:0]);
        tick();
        setMem(1'b1, 1'b1, 32'hDEAD_0000, 64'hBAD0_BAD0_BAD0_BAD0);
        tick();
        for (int k = 1; k < 4; k++) begin
            setMem(1'b1, 1'b1, 32'h0000_2000, line[k*64 +: 64]);
            tick();
            if (k == 3) setMem(1'b1, 1'b0, 32'd0, 64'd0);
            else checkOutput($sformatf("stray early resp b%0d", k), 256'(iResp), 256'd0);
        end
        checkOutput("stray i_resp", 256'(iResp), 256'd1);
        checkOutput("stray i_rdata", iRdata, line);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        // Reset after two read beats aborts the burst; late beats are dropped.
        line = randLine();
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'd0, 256'd0);
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        tick();
        tick();
        setMem(1'b1, 1'b1, 32'h0000_3000, line[63:0]);
        tick();
        setMem(1'b1, 1'b1, 32'h0000_3000, line[127:64]);
        tick();
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        #2 rst = 1'b1;
        #1 checkAllZero("rstmid");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();
        rst = 1'b0;
        setMem(1'b1, 1'b1, 32'h0000_3000, line[191:128]);
        tick();
        setMem(1'b1, 1'b1, 32'h0000_3000, line[255:192]);
        checkOutput("rstmid late beat resp", 256'(iResp), 256'd0);
        tick();
        setMem(1'b1, 1'b0, 32'd0, 64'd0);
        checkOutput("rstmid late beats dropped", iRdata, 256'd0);
        checkOutput("rstmid late no read", 256'(bRead), 256'd0);
        tick();
        checkOutput("rstmid no resp", 256'(iResp), 256'd0);
        line = randLine();
        applyStimulus(1'b1, 32'h0000_3004, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();
        checkOutput("rstmid retry addr", 256'(bAddr), 256'h3000);
        tick();
        serveBeats(32'h0000_3000, line);
        checkOutput("rstmid retry i_resp", 256'(iResp), 256'd1);
        checkOutput("rstmid retry i_rdata", iRdata, line);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        doReset();
        runRandom(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
